// File: rtl/ctrl_pipeline_if.sv
// ctrl_pipeline_if
// Bundles the decoded-instruction inputs and the pipeline-control outputs of
// ctrl_pipeline so the decode stage (master) and the control block (slave)
// connect through a single port.
//
// Signals (direction seen from the slave / ctrl_pipeline):
//   in : i_enable, i_valid, i_halt, i_flush
//        i_control_EX_ALUOp[1:0], i_control_EX_ALUSrc, i_control_EX_regDst
//        i_control_M_branch[1:0], i_control_M_memRead, i_control_M_memWrite
//        i_control_WB_memtoReg, i_control_WB_regWrite
//        i_rs, i_rt, i_rd [N_BITS_REG-1:0]
//   out: o_EX_ALUOp[1:0], o_EX_ALUSrc, o_EX_regDst          (ID/EX)
//        o_M_branch[1:0], o_M_memRead, o_M_memWrite          (EX/MEM)
//        o_WB_memtoReg, o_WB_regWrite                        (MEM/WB)
//        o_exmem_dst, o_memwb_dst [N_BITS_REG-1:0]
//        o_fwd_a, o_fwd_b [1:0], o_stall, o_halted
//        o_state[1:0]  (FSM state, debug visibility)
//
// Handshake: there is no ready/valid pair here. i_valid qualifies the decoded
// instruction on every enabled clock edge; o_stall=1 means the upstream must
// re-present the same instruction on the next cycle (PC and IF/ID held).
interface ctrl_pipeline_if #(
    parameter int N_BITS_REG = 5
);
    logic                  i_enable;
    logic                  i_valid;
    logic                  i_halt;
    logic                  i_flush;
    logic [1:0]            i_control_EX_ALUOp;
    logic                  i_control_EX_ALUSrc;
    logic                  i_control_EX_regDst;
    logic [1:0]            i_control_M_branch;
    logic                  i_control_M_memRead;
    logic                  i_control_M_memWrite;
    logic                  i_control_WB_memtoReg;
    logic                  i_control_WB_regWrite;
    logic [N_BITS_REG-1:0] i_rs;
    logic [N_BITS_REG-1:0] i_rt;
    logic [N_BITS_REG-1:0] i_rd;

    logic [1:0]            o_EX_ALUOp;
    logic                  o_EX_ALUSrc;
    logic                  o_EX_regDst;
    logic [1:0]            o_M_branch;
    logic                  o_M_memRead;
    logic                  o_M_memWrite;
    logic                  o_WB_memtoReg;
    logic                  o_WB_regWrite;
    logic [N_BITS_REG-1:0] o_exmem_dst;
    logic [N_BITS_REG-1:0] o_memwb_dst;
    logic [1:0]            o_fwd_a;
    logic [1:0]            o_fwd_b;
    logic                  o_stall;
    logic                  o_halted;
    logic [1:0]            o_state;

    modport master (
        output i_enable, i_valid, i_halt, i_flush,
               i_control_EX_ALUOp, i_control_EX_ALUSrc, i_control_EX_regDst,
               i_control_M_branch, i_control_M_memRead, i_control_M_memWrite,
               i_control_WB_memtoReg, i_control_WB_regWrite,
               i_rs, i_rt, i_rd,
        input  o_EX_ALUOp, o_EX_ALUSrc, o_EX_regDst,
               o_M_branch, o_M_memRead, o_M_memWrite,
               o_WB_memtoReg, o_WB_regWrite,
               o_exmem_dst, o_memwb_dst, o_fwd_a, o_fwd_b,
               o_stall, o_halted, o_state
    );

    modport slave (
        input  i_enable, i_valid, i_halt, i_flush,
               i_control_EX_ALUOp, i_control_EX_ALUSrc, i_control_EX_regDst,
               i_control_M_branch, i_control_M_memRead, i_control_M_memWrite,
               i_control_WB_memtoReg, i_control_WB_regWrite,
               i_rs, i_rt, i_rd,
        output o_EX_ALUOp, o_EX_ALUSrc, o_EX_regDst,
               o_M_branch, o_M_memRead, o_M_memWrite,
               o_WB_memtoReg, o_WB_regWrite,
               o_exmem_dst, o_memwb_dst, o_fwd_a, o_fwd_b,
               o_stall, o_halted, o_state
    );
endinterface

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline
// Control path of a 5-stage pipeline: carries the decoded EX/MEM/WB controls
// through the ID/EX, EX/MEM and MEM/WB registers, detects load-use hazards,
// produces EX-operand forwarding selects and drains the pipeline after HALT.
//
// Ports:
//   i_clk   : clock, all state updates on the rising edge
//   i_reset : asynchronous active-high reset
//   bus     : ctrl_pipeline_if.slave (decoded inputs, stage contents,
//             forwarding selects, stall, halted, FSM state)
module ctrl_pipeline #(
    parameter int N_BITS_REG = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    ctrl_pipeline_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0]            alu_op;
        logic                  alu_src;
        logic                  reg_dst;
        logic [1:0]            branch;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [N_BITS_REG-1:0] rs;
        logic [N_BITS_REG-1:0] rt;
        logic [N_BITS_REG-1:0] dst;
        logic                  valid;
    } idex_t;

    typedef struct packed {
        logic [1:0]            branch;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [N_BITS_REG-1:0] dst;
    } exmem_t;

    typedef struct packed {
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [N_BITS_REG-1:0] dst;
    } memwb_t;

    state_e                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  halted_q, halted_d;
    idex_t                 idex_q, idex_d;
    exmem_t                exmem_q, exmem_d;
    memwb_t                memwb_q, memwb_d;

    logic [N_BITS_REG-1:0] dst_in;
    logic                  halt_take;
    logic                  hazard;
    logic                  stall_c;
    logic                  bubble;
    logic [1:0]            fwd_a_c;
    logic [1:0]            fwd_b_c;

    always_comb begin
        dst_in    = bus.i_control_EX_regDst ? bus.i_rd : bus.i_rt;
        halt_take = (state_q == ST_RUN) && bus.i_valid && bus.i_halt;

        // Load-use: the load in EX cannot forward in time to the instruction
        // now in ID, so that instruction must wait one cycle.
        hazard  = idex_q.valid && idex_q.mem_read && (idex_q.dst != '0) &&
                  ((idex_q.dst == bus.i_rs) || (idex_q.dst == bus.i_rt));
        // A flush squashes the waiting instruction anyway, so no stall then.
        stall_c = bus.i_enable && bus.i_valid && (state_q == ST_RUN) &&
                  hazard && !bus.i_flush;

        bubble = (state_q != ST_RUN) || !bus.i_valid || bus.i_flush ||
                 halt_take || stall_c;

        idex_d = '0;
        if (!bubble) begin
            idex_d.alu_op     = bus.i_control_EX_ALUOp;
            idex_d.alu_src    = bus.i_control_EX_ALUSrc;
            idex_d.reg_dst    = bus.i_control_EX_regDst;
            idex_d.branch     = bus.i_control_M_branch;
            idex_d.mem_read   = bus.i_control_M_memRead;
            idex_d.mem_write  = bus.i_control_M_memWrite;
            idex_d.mem_to_reg = bus.i_control_WB_memtoReg;
            idex_d.reg_write  = bus.i_control_WB_regWrite;
            idex_d.rs         = bus.i_rs;
            idex_d.rt         = bus.i_rt;
            idex_d.dst        = dst_in;
            idex_d.valid      = 1'b1;
        end

        // Once halted every stage is pinned at zero.
        exmem_d = '0;
        memwb_d = '0;
        if (state_q != ST_HALTED) begin
            exmem_d.branch     = idex_q.branch;
            exmem_d.mem_read   = idex_q.mem_read;
            exmem_d.mem_write  = idex_q.mem_write;
            exmem_d.mem_to_reg = idex_q.mem_to_reg;
            exmem_d.reg_write  = idex_q.reg_write;
            exmem_d.dst        = idex_q.dst;
            memwb_d.mem_to_reg = exmem_q.mem_to_reg;
            memwb_d.reg_write  = exmem_q.reg_write;
            memwb_d.dst        = exmem_q.dst;
        end

        state_d  = state_q;
        cnt_d    = cnt_q;
        halted_d = halted_q;
        case (state_q)
            ST_RUN: begin
                if (halt_take) begin
                    state_d = ST_DRAIN;
                    cnt_d   = 2'd0;
                end
            end
            ST_DRAIN: begin
                // Three enabled edges after HALT flush the last real
                // instruction out of MEM/WB.
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd2) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end
            end
            ST_HALTED: begin
                halted_d = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // EX/MEM has the newer value, so it wins over MEM/WB.
        fwd_a_c = 2'b00;
        if (exmem_q.reg_write && (exmem_q.dst != '0) && (exmem_q.dst == idex_q.rs))
            fwd_a_c = 2'b10;
        else if (memwb_q.reg_write && (memwb_q.dst != '0) && (memwb_q.dst == idex_q.rs))
            fwd_a_c = 2'b01;

        fwd_b_c = 2'b00;
        if (exmem_q.reg_write && (exmem_q.dst != '0) && (exmem_q.dst == idex_q.rt))
            fwd_b_c = 2'b10;
        else if (memwb_q.reg_write && (memwb_q.dst != '0) && (memwb_q.dst == idex_q.rt))
            fwd_b_c = 2'b01;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_RUN;
            cnt_q    <= 2'd0;
            halted_q <= 1'b0;
            idex_q   <= '0;
            exmem_q  <= '0;
            memwb_q  <= '0;
        end else if (bus.i_enable) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
            idex_q   <= idex_d;
            exmem_q  <= exmem_d;
            memwb_q  <= memwb_d;
        end
    end

    assign bus.o_EX_ALUOp    = idex_q.alu_op;
    assign bus.o_EX_ALUSrc   = idex_q.alu_src;
    assign bus.o_EX_regDst   = idex_q.reg_dst;
    assign bus.o_M_branch    = exmem_q.branch;
    assign bus.o_M_memRead   = exmem_q.mem_read;
    assign bus.o_M_memWrite  = exmem_q.mem_write;
    assign bus.o_WB_memtoReg = memwb_q.mem_to_reg;
    assign bus.o_WB_regWrite = memwb_q.reg_write;
    assign bus.o_exmem_dst   = exmem_q.dst;
    assign bus.o_memwb_dst   = memwb_q.dst;
    assign bus.o_fwd_a       = fwd_a_c;
    assign bus.o_fwd_b       = fwd_b_c;
    assign bus.o_stall       = stall_c;
    assign bus.o_halted      = halted_q;
    assign bus.o_state       = state_q;

endmodule
